// File: rtl/apb_master_mux.sv
// ---------------------------------------------------------------------------
// apb_master_mux
// APB4 master between the CPU MEM-stage load/store port and NUM_SLV APB
// slaves. Accepts one request at a time over a valid/ready handshake,
// decodes the slave index from req_addr[SLV_SEL_LSB +: SW] into a one-hot
// PSEL, runs the SETUP/ACCESS sequence and returns a one-cycle response
// pulse carrying read data and an error flag (slave error, decode error or
// wait-state timeout). All APB outputs and response outputs are registered.
//
// Ports
//   PCLK, PRESETn        clock / synchronous active-high reset (1 = reset)
//   req_*                CPU request channel (valid/ready)
//   rsp_*                CPU response pulse (no backpressure)
//   PADDR..PSTRB         registered APB master outputs
//   PRDATA/PREADY/PSLVERR  per-slave inputs, slave i in slice i
// ---------------------------------------------------------------------------
module apb_master_mux #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_SEL_LSB = 12,
    parameter int TIMEOUT     = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int SW     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int STRB_W = DATA_W / 8;
    // Counter only needs to reach TIMEOUT-1: the abort fires on that cycle.
    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW:0]   LP_NSLV     = (SW+1)'(NUM_SLV);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [SW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_n;
    logic                r_derr_pend;
    logic [ADDR_W-1:0]   r_paddr;
    logic [NUM_SLV-1:0]  r_psel;
    logic [NUM_SLV-1:0]  w_psel_n;
    logic                r_penable;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic [SW-1:0]       w_req_idx;
    logic [SW-1:0]       w_idx_n;
    logic                w_req_ok;
    logic                w_sel_ready;
    logic                w_sel_err;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic                w_timeout;
    logic                w_completing;
    logic                w_accept;
    logic                w_acc_ok;
    logic                w_acc_bad;
    logic                w_rsp_valid_n;
    logic                w_rsp_err_n;
    logic [DATA_W-1:0]   w_rsp_rdata_n;
    logic                w_derr_pend_n;

    assign w_req_idx = req_addr[SLV_SEL_LSB +: SW];
    assign w_req_ok  = ({1'b0, w_req_idx} < LP_NSLV);

    // Only the addressed slave's handshake and data are looked at.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == SW'(i)) begin
                w_sel_ready = PREADY[i];
                w_sel_err   = PSLVERR[i];
                w_sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout    = (TIMEOUT > 0) && (r_state == ST_ACCESS) && !w_sel_ready
                          && (r_cnt == LP_CNT_LAST);
    assign w_completing = (r_state == ST_ACCESS) && (w_sel_ready || w_timeout);

    // A decode error accepted on a completion edge has its response deferred
    // by one cycle; new requests are held off until that response goes out.
    assign req_ready = ((r_state == ST_IDLE) && !r_derr_pend) || w_completing;
    assign w_accept  = req_valid && req_ready;
    assign w_acc_ok  = w_accept && w_req_ok;
    assign w_acc_bad = w_accept && !w_req_ok;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE:   if (w_acc_ok) w_state_n = ST_SETUP;
            ST_SETUP:  w_state_n = ST_ACCESS;
            ST_ACCESS: if (w_completing) w_state_n = w_acc_ok ? ST_SETUP : ST_IDLE;
            default:   w_state_n = ST_IDLE;
        endcase

        w_idx_n = w_acc_ok ? w_req_idx : r_idx;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_psel_n[i] = (w_state_n != ST_IDLE) && (w_idx_n == SW'(i));
        end

        w_cnt_n = r_cnt;
        if (w_completing) begin
            w_cnt_n = '0;
        end else if ((TIMEOUT > 0) && (r_state == ST_ACCESS) && !w_sel_ready) begin
            w_cnt_n = r_cnt + CW'(1);
        end

        w_derr_pend_n = w_acc_bad && w_completing;
        w_rsp_valid_n = w_completing || r_derr_pend || w_acc_bad;
        // Not ready while completing can only mean the timeout fired.
        w_rsp_err_n   = w_completing ? (!w_sel_ready || w_sel_err) : (r_derr_pend || w_acc_bad);
        w_rsp_rdata_n = (w_completing && w_sel_ready && !w_sel_err && !r_pwrite) ? w_sel_rdata : '0;
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_derr_pend <= 1'b0;
            r_paddr     <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_cnt       <= w_cnt_n;
            r_derr_pend <= w_derr_pend_n;
            r_psel      <= w_psel_n;
            r_penable   <= (w_state_n == ST_ACCESS);
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_err   <= w_rsp_valid_n && w_rsp_err_n;
            r_rsp_rdata <= w_rsp_rdata_n;
            if (w_acc_ok) begin
                r_idx    <= w_req_idx;
                r_paddr  <= req_addr;
                r_pwrite <= req_write;
                r_pwdata <= req_write ? req_wdata : '0;
                r_pstrb  <= req_write ? req_strb : '0;
            end else if (w_state_n == ST_IDLE) begin
                r_paddr  <= '0;
                r_pwrite <= 1'b0;
                r_pwdata <= '0;
                r_pstrb  <= '0;
            end
        end
    end

    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised APB4 master bridging the CPU load/store path to NUM_SLV APB slaves (UART, timers, GPIO).
- Adds the following over the single-slave master:
  - valid/ready request and response handshake
  - address decode to a one-hot PSEL
  - PSLVERR propagation
  - wait-state timeout abort
  - back-to-back transfers
- All APB outputs are registered.
- Sits between the pipeline MEM stage and the peripheral bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8); strobe width is DATA_W/8
NUM_SLV, 4, number of slaves (1..16); SW = max(1, clog2(NUM_SLV))
SLV_SEL_LSB, 12, LSB of the slave-index field req_addr[SLV_SEL_LSB +: SW]
TIMEOUT, 16, max ACCESS wait cycles before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  reset, synchronous, active-high (1 = reset)
req_valid  in  1  CPU request valid
req_ready  out  1  master can accept request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_strb  in  DATA_W/8  byte strobes (writes only)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  slave error, decode error or timeout
PADDR  out  ADDR_W  APB address
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PRDATA  in  NUM_SLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLV  per-slave ready
PSLVERR  in  NUM_SLV  per-slave error

Behaviour:
- Reset: when PRESETn=1 at an edge:
  - state goes to IDLE; wait counter is cleared.
  - PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata and rsp_err are all 0.
  - Reset mid-transfer drops the transfer silently: no rsp_valid.
- States:
  - IDLE: APB outputs 0.
  - SETUP: PSEL[idx]=1, PENABLE=0.
  - ACCESS: PSEL[idx]=1, PENABLE=1.
- Accept: a request is accepted on an edge where req_valid & req_ready.
  - At accept, req_addr, req_write, req_wdata and req_strb are registered and stay stable on the APB bus until completion.
  - For reads, PWDATA=0 and PSTRB=0.
- req_ready = (state==IDLE) | completing. "completing" means the state is ACCESS and one of:
  - PREADY[idx]=1, or
  - the timeout is reached.
- Decode: idx = req_addr[SLV_SEL_LSB +: SW].
  - If idx >= NUM_SLV: no APB activity; state stays IDLE.
  - rsp_valid=1 and rsp_err=1 on the cycle after accept.
- Transitions:
  - IDLE -> SETUP on a valid-index accept.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> ACCESS while PREADY[idx]=0 and not timed out.
  - On completion: ACCESS -> SETUP if a new valid-index request is accepted on the same edge; otherwise ACCESS -> IDLE.
  - Back-to-back transfers therefore keep PSEL high with PENABLE low for the new SETUP.
- Latency (zero wait states):
  - accept edge E0 -> SETUP during cycle after E0 -> ACCESS after E1 -> PREADY sampled at E2.
  - rsp_valid is high for exactly the cycle after E2.
  - Each wait state adds one cycle.
- Response (registered at the completion edge):
  - rsp_rdata = PRDATA slice idx for reads without error; 0 otherwise.
  - rsp_err = PSLVERR[idx] sampled with PREADY, or the timeout.
  - rsp_valid is a single-cycle pulse; there is no backpressure on the response.
- Timeout (TIMEOUT>0):
  - The counter increments on each ACCESS cycle with PREADY[idx]=0.
  - When the count reaches TIMEOUT, the transfer completes at that edge: PSEL and PENABLE drop, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The counter clears on every completion.
- PREADY, PSLVERR and PRDATA of non-selected slaves are ignored.
- PSEL has at most one bit set at all times.

Test Plan:
1. Write addr 0x0000_1008, data 0xDEADBEEF, strb 0xF, slave 1 PREADY tied 1:
   - PSEL=4'b0010 for 2 cycles, PENABLE high in 2nd cycle, PWDATA=0xDEADBEEF, PSTRB=0xF.
   - rsp_valid pulses 3 cycles after accept with rsp_err=0, rsp_rdata=0.
2. Read addr 0x0000_2000, slave 2 PRDATA=0x12345678 with 3 wait states:
   - PENABLE high 4 cycles, PWDATA=0, PSTRB=0.
   - rsp_rdata=0x12345678, rsp_valid 6 cycles after accept.
3. Read slave 3 with PSLVERR=1 at PREADY -> rsp_err=1, rsp_rdata=0.
4. Two back-to-back reads to slaves 0 then 1, req_valid held high, zero wait:
   - Second SETUP immediately follows first ACCESS (PSEL 0001 -> 0010, PENABLE 1 -> 0).
   - Two rsp_valid pulses 2 cycles apart.
5. TIMEOUT=16, slave PREADY stuck 0:
   - PENABLE high 16 cycles then PSEL/PENABLE drop.
   - rsp_valid=1, rsp_err=1; the next request is accepted normally.
6. NUM_SLV=3, access idx 3 -> no PSEL, rsp_err pulse next cycle.
   - Also: PRESETn=1 during ACCESS -> all outputs 0 next cycle and no rsp_valid.
